ula_seq: RTL and testbench

Parametrised, registered successor to the 8-bit combinational ULA used in the nRISC datapath.
- Adds an operand width parameter, a 3-bit op code, shifts, unsigned compare, AND, a signed-overflow flag, and an iterative shift-add multiplier.
- Uses a start/busy/done handshake.
- Sits between the register file and write-back. The control unit stalls on busy.

---
 rtl/ula_seq.sv | 162 ++++++++++++++++
 tb/tb_ula_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// Registered, parametrised ULA with a start/busy/done handshake.
// Single-cycle ops complete at the start edge; multiply iterates shift-add for WIDTH cycles.
module ula_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ULAop,
  input  logic [WIDTH-1:0] dado1,
  input  logic [WIDTH-1:0] dado2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultado,
  output logic             notzero,
  output logic             overflow
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_SRA  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             nz_pend_q, nz_pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] resultado_q, resultado_d;
  logic             notzero_q, notzero_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] sum, diff, alu_res, acc_next;
  logic [SHW-1:0]   amt;
  logic             alu_ov;

  // Single-cycle datapath
  always_comb begin
    sum     = dado1 + dado2;
    diff    = dado1 - dado2;
    amt     = dado2[SHW-1:0];
    alu_res = '0;
    alu_ov  = 1'b0;
    case (ULAop)
      OP_ADD: begin
        alu_res = sum;
        alu_ov  = (dado1[WIDTH-1] == dado2[WIDTH-1]) && (sum[WIDTH-1] != dado1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ov  = (dado1[WIDTH-1] != dado2[WIDTH-1]) && (diff[WIDTH-1] != dado1[WIDTH-1]);
      end
      OP_SLT:  alu_res = WIDTH'($signed(dado1) < $signed(dado2));
      OP_SLTU: alu_res = WIDTH'(dado1 < dado2);
      OP_SLL:  alu_res = dado1 << amt;
      OP_SRA:  alu_res = WIDTH'($signed(dado1) >>> amt);
      OP_MUL:  alu_res = '0;
      OP_AND:  alu_res = dado1 & dado2;
      default: alu_res = '0;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    count_d     = count_q;
    nz_pend_d   = nz_pend_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    resultado_d = resultado_q;
    notzero_d   = notzero_q;
    overflow_d  = overflow_q;
    acc_next    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (MUL_EN && (ULAop == OP_MUL)) begin
            state_d   = MUL;
            mcand_d   = dado1;
            mplier_d  = dado2;
            acc_d     = '0;
            count_d   = CW'(WIDTH);
            nz_pend_d = |dado1;
            busy_d    = 1'b1;
          end else begin
            resultado_d = alu_res;
            overflow_d  = alu_ov;
            notzero_d   = |dado1;
            done_d      = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          resultado_d = acc_next;
          overflow_d  = 1'b0;
          notzero_d   = nz_pend_q;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      nz_pend_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      resultado_q <= '0;
      notzero_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      nz_pend_q   <= nz_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      resultado_q <= resultado_d;
      notzero_q   <= notzero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign resultado = resultado_q;
  assign notzero   = notzero_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq: a MUL_EN=1 and a MUL_EN=0 instance at WIDTH=8.
module tb_ula_seq;

  logic       clock;
  logic       reset;
  logic       start;
  logic [2:0] ULAop;
  logic [7:0] dado1, dado2;
  logic       busy, done, notzero, overflow;
  logic [7:0] resultado;

  logic       z_start;
  logic [2:0] z_op;
  logic [7:0] z_a, z_b;
  logic       z_busy, z_done, z_nz, z_ov;
  logic [7:0] z_res;

  int checks = 0;
  int errors = 0;

  ula_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start), .ULAop(ULAop),
    .dado1(dado1), .dado2(dado2), .busy(busy), .done(done),
    .resultado(resultado), .notzero(notzero), .overflow(overflow)
  );

  ula_seq #(.WIDTH(8), .MUL_EN(1'b0)) dut_nomul (
    .clock(clock), .reset(reset), .start(z_start), .ULAop(z_op),
    .dado1(z_a), .dado2(z_b), .busy(z_busy), .done(z_done),
    .resultado(z_res), .notzero(z_nz), .overflow(z_ov)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    start = 1'b1;
    ULAop = op;
    dado1 = a;
    dado2 = b;
  endtask

  task automatic check_out(input string tag, input logic [7:0] res, input logic nz,
                           input logic ov, input logic dn, input logic bz);
    check({tag, "_res"}, 32'(resultado), 32'(res));
    check({tag, "_nz"}, 32'(notzero), 32'(nz));
    check({tag, "_ov"}, 32'(overflow), 32'(ov));
    check({tag, "_done"}, 32'(done), 32'(dn));
    check({tag, "_busy"}, 32'(busy), 32'(bz));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; ULAop = 3'b000; dado1 = 8'h00; dado2 = 8'h00;
    z_start = 1'b0; z_op = 3'b000; z_a = 8'h00; z_b = 8'h00;
    step(); step();
    reset = 1'b1;
    check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Multiply aborted by reset at the 4th iteration edge
    issue(3'b110, 8'h0D, 8'h0B);
    step();
    start = 1'b0;
    check("abort_busy", 32'(busy), 32'd1);
    step(); step(); step();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    check_out("abort", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b000, 8'h02, 8'h03);
    step();
    start = 1'b0;
    check_out("post_reset_add", 8'h05, 1'b1, 1'b0, 1'b1, 1'b0);

    // Add overflow
    issue(3'b000, 8'h7F, 8'h01);
    step();
    start = 1'b0;
    check_out("add_ovf", 8'h80, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    check("add_ovf_pulse", 32'(done), 32'd0);
    check("add_ovf_hold", 32'(resultado), 32'h80);
    issue(3'b000, 8'hFF, 8'h01);
    step();
    start = 1'b0;
    check_out("add_wrap", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

    // Sub and compares
    issue(3'b001, 8'h00, 8'h01);
    step();
    check_out("sub_neg", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(3'b001, 8'h80, 8'h01);
    step();
    check_out("sub_ovf", 8'h7F, 1'b1, 1'b1, 1'b1, 1'b0);
    issue(3'b010, 8'hFF, 8'h01);
    step();
    check_out("slt", 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(3'b011, 8'hFF, 8'h01);
    step();
    start = 1'b0;
    check_out("sltu", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    step();

    // Multiply 13*11 with an ignored add start mid-run
    issue(3'b110, 8'h0D, 8'h0B);
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("mul1_busy%0d", i), 32'(busy), 32'd1);
      check($sformatf("mul1_done%0d", i), 32'(done), 32'd0);
      check($sformatf("mul1_hold%0d", i), 32'(resultado), 32'h00);
      if (i == 3) issue(3'b000, 8'h01, 8'h01);
      else start = 1'b0;
      step();
    end
    check_out("mul1", 8'h8F, 1'b1, 1'b0, 1'b1, 1'b0);

    // Back-to-back multiply accepted in the done cycle
    issue(3'b110, 8'hFF, 8'hFF);
    step();
    start = 1'b0;
    check("mul2_busy_start", 32'(busy), 32'd1);
    check("mul2_done_start", 32'(done), 32'd0);
    for (int i = 0; i < 8; i++) step();
    check_out("mul2", 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check_out("mul2_hold", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);

    // Shifts and AND
    issue(3'b101, 8'h90, 8'h0B);
    step();
    check_out("sra", 8'hF2, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(3'b100, 8'h81, 8'h01);
    step();
    check_out("sll", 8'h02, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(3'b111, 8'hF0, 8'h3C);
    step();
    start = 1'b0;
    check_out("and", 8'h30, 1'b1, 1'b0, 1'b1, 1'b0);
    step();

    // Three back-to-back adds
    issue(3'b000, 8'h01, 8'h01);
    step();
    check_out("b2b_1", 8'h02, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(3'b000, 8'h02, 8'h02);
    step();
    check_out("b2b_2", 8'h04, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(3'b000, 8'h03, 8'h03);
    step();
    start = 1'b0;
    check_out("b2b_3", 8'h06, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check("b2b_end_done", 32'(done), 32'd0);

    // MUL_EN=0 build: op 110 is single-cycle with zero result
    z_start = 1'b1; z_op = 3'b110; z_a = 8'h05; z_b = 8'h03;
    step();
    z_start = 1'b0;
    check("nomul_res", 32'(z_res), 32'h00);
    check("nomul_done", 32'(z_done), 32'd1);
    check("nomul_busy", 32'(z_busy), 32'd0);
    check("nomul_nz", 32'(z_nz), 32'd1);
    step();
    check("nomul_done_end", 32'(z_done), 32'd0);
    check("nomul_busy_end", 32'(z_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
